i2s_ser: RTL



---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_sclk_gen.sv | 40 ++++
 rtl/i2s_ser.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S serialiser.
package i2s_pkg;

  localparam int unsigned SAMPLE_W     = 24;
  localparam int unsigned FRAME_W      = 48;
  localparam int unsigned SLOTS_PER_CH = 24;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } i2s_ser_state_t;

endpackage

// File: rtl/i2s_sclk_gen.sv
// Serial clock generator: sclk = clk / (2 * SCLK_DIV), with single-clk strobes
// flagging the clk edge on which sclk rises or falls. Held idle while run=0.
module i2s_sclk_gen #(
  parameter int unsigned SCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic sclk_fall,
  output logic sclk_rise
);

  logic [7:0] cnt_q;
  logic       sclk_q;
  logic       wrap;

  assign wrap      = run && (cnt_q == 8'(SCLK_DIV - 1));
  // Strobes are valid in the cycle whose closing edge toggles sclk.
  assign sclk_rise = wrap & ~sclk_q;
  assign sclk_fall = wrap & sclk_q;
  assign sclk      = sclk_q;

  // Half-period counter; wraps and toggles sclk, parked at zero while stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!run) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (wrap) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/i2s_ser.sv
// I2S transmitter: one-deep stereo sample buffer feeding a 48-slot MSB-first
// serialiser. Optional feature macro I2S_SER_UNDERRUN_EN adds an underrun
// pulse output and sends a muted frame on underrun instead of repeating.
module i2s_ser
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 8,
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] lft_in,
  input  logic [SAMPLE_W-1:0] rght_in,
  input  logic                vld_in,
  output logic                rdy,
  output logic                frm_strt,
  output logic                busy,
  output logic                I2S_sclk,
  output logic                I2S_ws,
`ifdef I2S_SER_UNDERRUN_EN
  output logic                underrun,
`endif
  output logic                I2S_data
);

  localparam int unsigned FW = 2 * SAMPLE_W;
  localparam int unsigned CW = $clog2(FW);

  i2s_ser_state_t state_q;
  logic [FW-1:0]  buf_q;
  logic           buf_vld_q;
  logic [FW-1:0]  shift_q;
  logic [CW-1:0]  bit_cnt_q;
  logic           ws_q, data_q, frm_strt_q, busy_q;
  logic           sclk_fall, sclk_rise;
  logic           accept, boundary, load, underrun_hit;
  logic [FW-1:0]  load_frame;

  i2s_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state_q != IDLE),
    .sclk      (I2S_sclk),
    .sclk_fall (sclk_fall),
    .sclk_rise (sclk_rise)
  );

  // Load decisions: from IDLE once a pair waits, or at each frame boundary while enabled.
  always_comb begin
    accept       = vld_in & ~buf_vld_q;
    boundary     = (state_q == RIGHT) && sclk_fall && (bit_cnt_q == CW'(FW - 1));
    load         = ((state_q == IDLE) && en && buf_vld_q) || (boundary && en);
    underrun_hit = boundary && en && !buf_vld_q;
`ifdef I2S_SER_UNDERRUN_EN
    load_frame   = underrun_hit ? '0 : buf_q;
`else
    // buf_q keeps its contents after a load, so an underrun simply repeats it.
    load_frame   = buf_q;
`endif
  end

  // One-deep buffer; a same-clk load takes the old contents before the new pair lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
    end else if (accept) begin
      buf_q     <= {lft_in, rght_in};
      buf_vld_q <= 1'b1;
    end else if (load) begin
      buf_vld_q <= 1'b0;
    end
  end

  // Frame FSM: shifts on every sclk fall, moves ws one slot ahead of each channel MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ws_q       <= 1'b1;
      data_q     <= 1'b0;
      frm_strt_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      frm_strt_q <= load;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            shift_q   <= {load_frame[FW-2:0], 1'b0};
            data_q    <= load_frame[FW-1];
            ws_q      <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= LEFT;
            busy_q    <= 1'b1;
          end
        end
        LEFT: begin
          if (sclk_fall) begin
            shift_q   <= {shift_q[FW-2:0], 1'b0};
            data_q    <= shift_q[FW-1];
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CW'(SAMPLE_W - 2)) ws_q <= 1'b1;
            if (bit_cnt_q == CW'(SAMPLE_W - 1)) state_q <= RIGHT;
          end
        end
        RIGHT: begin
          if (sclk_fall) begin
            if (bit_cnt_q == CW'(FW - 1)) begin
              bit_cnt_q <= '0;
              if (en) begin
                shift_q <= {load_frame[FW-2:0], 1'b0};
                data_q  <= load_frame[FW-1];
                ws_q    <= 1'b0;
                state_q <= LEFT;
              end else begin
                data_q  <= 1'b0;
                ws_q    <= 1'b1;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              shift_q   <= {shift_q[FW-2:0], 1'b0};
              data_q    <= shift_q[FW-1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CW'(FW - 2)) ws_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef I2S_SER_UNDERRUN_EN
  logic underrun_q, underrun_sts_q;

  // Underrun pulse and sticky status; a fresh underrun wins over a same-clk accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q     <= 1'b0;
      underrun_sts_q <= 1'b0;
    end else begin
      underrun_q <= underrun_hit;
      if (underrun_hit)  underrun_sts_q <= 1'b1;
      else if (accept)   underrun_sts_q <= 1'b0;
    end
  end

  assign underrun = underrun_q;
`endif

  assign rdy      = ~buf_vld_q;
  assign frm_strt = frm_strt_q;
  assign busy     = busy_q;
  assign I2S_ws   = ws_q;
  assign I2S_data = data_q;

  logic unused_rise;
  assign unused_rise = sclk_rise;

endmodule
